// File: rtl/dm_bus_arbiter.sv
// Round-robin arbiter sharing the data-memory port between M0 (CPU LSU) and M1 (DMA/debug).
// Optional grant/conflict counters are built when DM_ARB_PERF_EN is defined.
module dm_bus_arbiter #(
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_byteen,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_byteen,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byteen,
   input  logic [31:0] mem_rdata
`ifdef DM_ARB_PERF_EN
   ,
   output logic [31:0] m0_gnt_cnt,
   output logic [31:0] m1_gnt_cnt,
   output logic [31:0] conflict_cnt
`endif
);

   typedef enum logic {
      PRI_M0 = 1'b0,
      PRI_M1 = 1'b1
   } pri_e;

   pri_e        ptr_q, ptr_d;
   logic        gnt0, gnt1, any_gnt;
   logic        w_we;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic [3:0]  w_byteen;
   logic        zero_wr;

   // Owner pipeline: valid bit and owner id (0 = M0, 1 = M1) per stage.
   logic [RD_LAT-1:0] pv_q, pv_d;
   logic [RD_LAT-1:0] po_q, po_d;

   logic        rv_any;
   logic [31:0] m0_hold_q, m0_hold_d;
   logic [31:0] m1_hold_q, m1_hold_d;

   always_comb begin
      gnt0  = 1'b0;
      gnt1  = 1'b0;
      ptr_d = ptr_q;
      if (m0_req && m1_req) begin
         if (ptr_q == PRI_M0) begin
            gnt0 = 1'b1;
         end else begin
            gnt1 = 1'b1;
         end
      end else begin
         gnt0 = m0_req;
         gnt1 = m1_req;
      end
      if (gnt0) begin
         ptr_d = PRI_M1;
      end else if (gnt1) begin
         ptr_d = PRI_M0;
      end
   end

   assign any_gnt = gnt0 | gnt1;
   assign m0_gnt  = gnt0;
   assign m1_gnt  = gnt1;

   always_comb begin
      w_we     = 1'b0;
      w_addr   = 32'h0;
      w_wdata  = 32'h0;
      w_byteen = 4'h0;
      if (gnt1) begin
         w_we     = m1_we;
         w_addr   = m1_addr;
         w_wdata  = m1_wdata;
         w_byteen = m1_byteen;
      end else if (gnt0) begin
         w_we     = m0_we;
         w_addr   = m0_addr;
         w_wdata  = m0_wdata;
         w_byteen = m0_byteen;
      end
   end

   // A write with no byte lanes enabled is accepted but never reaches memory.
   assign zero_wr    = w_we && (w_byteen == 4'b0000);
   assign mem_en     = any_gnt && !zero_wr;
   assign mem_we     = any_gnt && w_we && !zero_wr;
   assign mem_addr   = w_addr & 32'hFFFF_FFFC;
   assign mem_wdata  = w_wdata;
   assign mem_byteen = w_we ? w_byteen : 4'b0000;

   always_comb begin
      pv_d    = '0;
      po_d    = '0;
      pv_d[0] = any_gnt && !w_we;
      po_d[0] = gnt1;
      for (int i = 1; i < RD_LAT; i++) begin
         pv_d[i] = pv_q[i-1];
         po_d[i] = po_q[i-1];
      end
   end

   assign rv_any    = pv_q[RD_LAT-1];
   assign m0_rvalid = rv_any && !po_q[RD_LAT-1];
   assign m1_rvalid = rv_any &&  po_q[RD_LAT-1];

   // Read data is forwarded in the response cycle and held until the next one.
   always_comb begin
      m0_hold_d = m0_hold_q;
      m1_hold_d = m1_hold_q;
      if (m0_rvalid) begin
         m0_hold_d = mem_rdata;
      end
      if (m1_rvalid) begin
         m1_hold_d = mem_rdata;
      end
   end

   assign m0_rdata = m0_rvalid ? mem_rdata : m0_hold_q;
   assign m1_rdata = m1_rvalid ? mem_rdata : m1_hold_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= PRI_M0;
         pv_q      <= '0;
         po_q      <= '0;
         m0_hold_q <= 32'h0;
         m1_hold_q <= 32'h0;
      end else begin
         ptr_q     <= ptr_d;
         pv_q      <= pv_d;
         po_q      <= po_d;
         m0_hold_q <= m0_hold_d;
         m1_hold_q <= m1_hold_d;
      end
   end

`ifdef DM_ARB_PERF_EN
   logic [31:0] m0_gnt_cnt_q, m0_gnt_cnt_d;
   logic [31:0] m1_gnt_cnt_q, m1_gnt_cnt_d;
   logic [31:0] conflict_cnt_q, conflict_cnt_d;

   always_comb begin
      m0_gnt_cnt_d   = m0_gnt_cnt_q;
      m1_gnt_cnt_d   = m1_gnt_cnt_q;
      conflict_cnt_d = conflict_cnt_q;
      if (gnt0) begin
         m0_gnt_cnt_d = m0_gnt_cnt_q + 32'd1;
      end
      if (gnt1) begin
         m1_gnt_cnt_d = m1_gnt_cnt_q + 32'd1;
      end
      if (m0_req && m1_req) begin
         conflict_cnt_d = conflict_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0_gnt_cnt_q   <= 32'h0;
         m1_gnt_cnt_q   <= 32'h0;
         conflict_cnt_q <= 32'h0;
      end else begin
         m0_gnt_cnt_q   <= m0_gnt_cnt_d;
         m1_gnt_cnt_q   <= m1_gnt_cnt_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign m0_gnt_cnt   = m0_gnt_cnt_q;
   assign m1_gnt_cnt   = m1_gnt_cnt_q;
   assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Directed bench for dm_bus_arbiter: one instance with RD_LAT=1 (a_*) and one with RD_LAT=3 (b_*)
// share the same master and memory stimulus.
module tb_dm_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;
   logic [3:0]  m0_byteen, m1_byteen;

   logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
   logic [31:0] a_m0_rdata, a_m1_rdata;
   logic        a_mem_en, a_mem_we;
   logic [31:0] a_mem_addr, a_mem_wdata;
   logic [3:0]  a_mem_byteen;
   logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
   logic [31:0] b_m0_rdata, b_m1_rdata;
   logic        b_mem_en, b_mem_we;
   logic [31:0] b_mem_addr, b_mem_wdata;
   logic [3:0]  b_mem_byteen;
`ifdef DM_ARB_PERF_EN
   logic [31:0] a_m0_gnt_cnt, a_m1_gnt_cnt, a_conflict_cnt;
   logic [31:0] b_m0_gnt_cnt, b_m1_gnt_cnt, b_conflict_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dm_bus_arbiter #(.RD_LAT(1)) u_lat1 (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_byteen(m0_byteen), .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_byteen(m1_byteen), .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_byteen(a_mem_byteen), .mem_rdata(mem_rdata)
`ifdef DM_ARB_PERF_EN
      , .m0_gnt_cnt(a_m0_gnt_cnt), .m1_gnt_cnt(a_m1_gnt_cnt), .conflict_cnt(a_conflict_cnt)
`endif
   );

   dm_bus_arbiter #(.RD_LAT(3)) u_lat3 (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_byteen(m0_byteen), .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_byteen(m1_byteen), .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_byteen(b_mem_byteen), .mem_rdata(mem_rdata)
`ifdef DM_ARB_PERF_EN
      , .m0_gnt_cnt(b_m0_gnt_cnt), .m1_gnt_cnt(b_m1_gnt_cnt), .conflict_cnt(b_conflict_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic idle();
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_byteen = 4'h0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_byteen = 4'h0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      settle();
      chk("rst_a_m0_rvalid", {31'h0, a_m0_rvalid}, 32'h0);
      chk("rst_a_m1_rvalid", {31'h0, a_m1_rvalid}, 32'h0);
      chk("rst_b_m0_rdata", b_m0_rdata, 32'h0);
      chk("rst_a_m1_rdata", a_m1_rdata, 32'h0);
      chk("rst_mem_en", {31'h0, a_mem_en}, 32'h0);
      chk("rst_mem_addr", a_mem_addr, 32'h0);
      next_cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      mem_rdata = 32'h0;
      do_reset();

      // Single-master read, RD_LAT=1
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0013;
      settle();
      chk("t1_m0_gnt", {31'h0, a_m0_gnt}, 32'h1);
      chk("t1_m1_gnt", {31'h0, a_m1_gnt}, 32'h0);
      chk("t1_mem_en", {31'h0, a_mem_en}, 32'h1);
      chk("t1_mem_we", {31'h0, a_mem_we}, 32'h0);
      chk("t1_mem_addr", a_mem_addr, 32'h0000_0010);
      chk("t1_mem_byteen", {28'h0, a_mem_byteen}, 32'h0);
      next_cycle();
      idle();
      mem_rdata = 32'hDEAD_BEEF;
      settle();
      chk("t1_m0_rvalid", {31'h0, a_m0_rvalid}, 32'h1);
      chk("t1_m0_rdata", a_m0_rdata, 32'hDEAD_BEEF);
      chk("t1_m1_rvalid", {31'h0, a_m1_rvalid}, 32'h0);
      next_cycle();
      mem_rdata = 32'h1111_1111;
      settle();
      chk("t1_m0_rvalid_off", {31'h0, a_m0_rvalid}, 32'h0);
      chk("t1_m0_rdata_hold", a_m0_rdata, 32'hDEAD_BEEF);
      next_cycle();
      next_cycle();

      // Contention from reset: M0, M1, M0, M1
      do_reset();
      for (int c = 0; c < 7; c++) begin
         m0_req = (c < 4); m0_we = 1'b0; m0_addr = 32'h0000_0040;
         m1_req = (c < 4); m1_we = 1'b0; m1_addr = 32'h0000_0080;
         mem_rdata = 32'h100 + c;
         settle();
         if (c < 4) begin
            chk($sformatf("t2_m0_gnt_c%0d", c), {31'h0, a_m0_gnt}, {31'h0, (c % 2) == 0});
            chk($sformatf("t2_m1_gnt_c%0d", c), {31'h0, a_m1_gnt}, {31'h0, (c % 2) == 1});
            chk($sformatf("t2_addr_c%0d", c), a_mem_addr, ((c % 2) == 0) ? 32'h40 : 32'h80);
         end
         chk($sformatf("t2_a_m0_rv_c%0d", c), {31'h0, a_m0_rvalid}, {31'h0, (c >= 1 && c <= 4 && ((c - 1) % 2) == 0)});
         chk($sformatf("t2_a_m1_rv_c%0d", c), {31'h0, a_m1_rvalid}, {31'h0, (c >= 1 && c <= 4 && ((c - 1) % 2) == 1)});
         chk($sformatf("t2_b_m0_rv_c%0d", c), {31'h0, b_m0_rvalid}, {31'h0, (c >= 3 && c <= 6 && ((c - 3) % 2) == 0)});
         chk($sformatf("t2_b_m1_rv_c%0d", c), {31'h0, b_m1_rvalid}, {31'h0, (c >= 3 && c <= 6 && ((c - 3) % 2) == 1)});
         if (c >= 1 && c <= 4) begin
            chk($sformatf("t2_a_rdata_c%0d", c), ((c - 1) % 2 == 0) ? a_m0_rdata : a_m1_rdata, 32'h100 + c);
         end
         if (c >= 3) begin
            chk($sformatf("t2_b_rdata_c%0d", c), ((c - 3) % 2 == 0) ? b_m0_rdata : b_m1_rdata, 32'h100 + c);
         end
`ifdef DM_ARB_PERF_EN
         if (c == 4) begin
            chk("t2_conflict_cnt", a_conflict_cnt, 32'd4);
            chk("t2_m0_gnt_cnt", a_m0_gnt_cnt, 32'd2);
            chk("t2_m1_gnt_cnt", a_m1_gnt_cnt, 32'd2);
         end
`endif
         next_cycle();
      end

      // M1 byte-lane write forwarding
      idle();
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0022; m1_byteen = 4'b1100; m1_wdata = 32'hABCD_0000;
      settle();
      chk("t3_m1_gnt", {31'h0, a_m1_gnt}, 32'h1);
      chk("t3_mem_en", {31'h0, a_mem_en}, 32'h1);
      chk("t3_mem_we", {31'h0, a_mem_we}, 32'h1);
      chk("t3_mem_addr", a_mem_addr, 32'h0000_0020);
      chk("t3_mem_byteen", {28'h0, a_mem_byteen}, 32'hC);
      chk("t3_mem_wdata", a_mem_wdata, 32'hABCD_0000);
      next_cycle();
      idle();
      for (int c = 0; c < 4; c++) begin
         settle();
         chk($sformatf("t3_a_m1_rv_%0d", c), {31'h0, a_m1_rvalid}, 32'h0);
         chk($sformatf("t3_b_m1_rv_%0d", c), {31'h0, b_m1_rvalid}, 32'h0);
         next_cycle();
      end

      // Zero-byteen write is granted, never forwarded, still moves the pointer
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0030; m0_byteen = 4'b0000; m0_wdata = 32'h5555_5555;
      settle();
      chk("t4_m0_gnt", {31'h0, a_m0_gnt}, 32'h1);
      chk("t4_mem_en", {31'h0, a_mem_en}, 32'h0);
      next_cycle();
      m0_we = 1'b0; m0_addr = 32'h0000_0044; m0_byteen = 4'h0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0084;
      settle();
      chk("t4_m1_gnt", {31'h0, a_m1_gnt}, 32'h1);
      chk("t4_m0_gnt_lost", {31'h0, a_m0_gnt}, 32'h0);
      chk("t4_mem_addr", a_mem_addr, 32'h0000_0084);
      chk("t4_no_zero_resp", {31'h0, a_m0_rvalid}, 32'h0);
      next_cycle();
      m1_req = 1'b0;
      mem_rdata = 32'h0BAD_F00D;
      settle();
      chk("t4_m0_gnt_next", {31'h0, a_m0_gnt}, 32'h1);
      chk("t4_m1_rvalid", {31'h0, a_m1_rvalid}, 32'h1);
      chk("t4_m1_rdata", a_m1_rdata, 32'h0BAD_F00D);
      chk("t4_m0_rvalid", {31'h0, a_m0_rvalid}, 32'h0);
      next_cycle();
      idle();
      for (int c = 0; c < 4; c++) next_cycle();

      // RD_LAT=3 back-to-back reads
      do_reset();
      for (int c = 0; c < 7; c++) begin
         m0_req = (c < 3); m0_we = 1'b0; m0_addr = 32'h0000_0100 + 4 * c;
         mem_rdata = 32'hA000 + c;
         settle();
         if (c < 3) chk($sformatf("t5_gnt_c%0d", c), {31'h0, b_m0_gnt}, 32'h1);
         chk($sformatf("t5_b_m0_rv_c%0d", c), {31'h0, b_m0_rvalid}, {31'h0, (c >= 3 && c <= 5)});
         chk($sformatf("t5_b_m1_rv_c%0d", c), {31'h0, b_m1_rvalid}, 32'h0);
         if (c >= 3 && c <= 5) chk($sformatf("t5_b_rdata_c%0d", c), b_m0_rdata, 32'hA000 + c);
         if (c == 6) chk("t5_b_rdata_hold", b_m0_rdata, 32'hA005);
         next_cycle();
      end
      idle();

      // Reset while reads are in flight
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0200;
      settle();
      chk("t6_m1_gnt", {31'h0, b_m1_gnt}, 32'h1);
      next_cycle();
      idle();
      m0_req = 1'b1; m0_addr = 32'h0000_0204;
      settle();
      chk("t6_m0_gnt", {31'h0, b_m0_gnt}, 32'h1);
      next_cycle();
      idle();
      rst_n = 1'b0;
      settle();
      chk("t6_rst_b_m1_rv", {31'h0, b_m1_rvalid}, 32'h0);
      next_cycle();
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         settle();
         chk($sformatf("t6_b_m1_rv_%0d", c), {31'h0, b_m1_rvalid}, 32'h0);
         chk($sformatf("t6_b_m0_rv_%0d", c), {31'h0, b_m0_rvalid}, 32'h0);
         chk($sformatf("t6_a_m0_rv_%0d", c), {31'h0, a_m0_rvalid}, 32'h0);
         next_cycle();
      end
      m0_req = 1'b1; m0_addr = 32'h0000_0300;
      m1_req = 1'b1; m1_addr = 32'h0000_0304;
      settle();
      chk("t6_ptr_m0_gnt", {31'h0, b_m0_gnt}, 32'h1);
      chk("t6_ptr_m1_gnt", {31'h0, b_m1_gnt}, 32'h0);
      next_cycle();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
